regfile: RTL and testbench
==========================

# regfile

General-purpose register file and operand-forwarding unit for the five-stage MIPS pipeline. Holds the 32×32-bit architectural registers and consumes the `reg_t` write bundles produced downstream: EX result, MEM result and the committing WB write. Serves the two ID-stage operand read ports, resolving RAW hazards by forwarding, and raises a stall request on load-use hazards. It is the consumer end of the write-register interface that the EX stage drives.

## Interface
Parameters:
- `NREGS`, 32: number of architectural registers. Address width is fixed at 5.
- `DW`, 32: register data width (matches `reg_data_t`).

Ports:
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `wb_wreg_i` in `reg_t`: committing write {en, addr, data} from the WB stage.
- `ex_wreg_i` in `reg_t`: in-flight result from EX, used for forwarding only.
- `ex_is_load_i` in 1: EX instruction is a load, so `ex_wreg_i.data` is not valid yet.
- `mem_wreg_i` in `reg_t`: in-flight result from MEM, used for forwarding only.
- `rd1_en_i` in 1: read port 1 enable.
- `rd1_addr_i` in 5: read port 1 address.
- `rd1_data_o` out `DW`: read port 1 data.
- `rd2_en_i` in 1: read port 2 enable.
- `rd2_addr_i` in 5: read port 2 address.
- `rd2_data_o` out `DW`: read port 2 data.
- `stall_req_o` out 1: load-use hazard; ID must hold.

## Operation
- Storage is `regs[0..31]`. `$zero` is hardwired: a write to addr 0 is discarded, and any read of addr 0 returns 0 regardless of forwarding sources.
- Write: on the rising edge, if `!rst && wb_wreg_i.en && wb_wreg_i.addr != 0`, then `regs[addr] <= data`.
- Reset: while `rst` is high at an edge, all 32 registers clear to 0. Any write in that cycle is dropped.
- Read port N (combinational) is resolved in strict priority order:
  1. `rst`, or `!rdN_en_i`: data 0.
  2. addr == 0: data 0.
  3. `ex_wreg_i.en` and address match: `ex_wreg_i.data`. If `ex_is_load_i` is set, the data is 0 instead and the port flags a hazard.
  4. `mem_wreg_i.en` and address match: `mem_wreg_i.data`.
  5. Same-cycle WB bypass. This applies only with `REGFILE_WB_BYPASS_EN`; see Configuration.
  6. Otherwise: `regs[addr]`.
- The youngest producer always wins: EX over MEM over WB over the array.
- `stall_req_o` = OR of both port hazards. It is 0 during `rst`, and 0 when the matching address is 0.
- A load in MEM is already valid and is forwarded normally; only an EX-stage load stalls.
- Both ports may hit the same source simultaneously; they are resolved independently and carry no interaction.

## Timing
- Read latency: 0 cycles (combinational from addresses and forwarding inputs).
- Write latency: the array updates at the edge ending the WB cycle. The value is visible from `regs` on the next cycle.
- Reset values:
  - `rd1_data_o` = 0, `rd2_data_o` = 0 and `stall_req_o` = 0 while `rst` is high.
  - Array contents are all 0 from the first cycle after `rst` deasserts.
- Reset mid-operation: an asserted `rst` overrides any pending WB write that cycle.
- `stall_req_o` stays high every cycle the hazard condition persists. No internal state is kept for the stall; the pipeline control advances EX to clear it.

## Configuration
- `REGFILE_WB_BYPASS_EN` defined:
  - A read whose address matches an enabled, nonzero `wb_wreg_i` returns `wb_wreg_i.data` in the same cycle, at priority step 5.
  - This gives ID/WB write-through.
- Not defined:
  - Step 5 is absent, and a read in the WB cycle returns the old array value.
  - The pipeline must then cover this case by another means, such as a write-first-half clocking scheme.

## Structure
- Package `project_types`: `reg_t`, `reg_data_t` and `reg_addr_t` (5-bit).
- Package `project_types` also holds `ZERO_WORD` and the `REG_ZERO` address constant.
- One sub-module `fwd_mux`, instantiated twice, once per read port.
  - Inputs: `en`, `addr`, `ex`, `ex_is_load`, `mem`, `wb`, `array_data`.
  - Outputs: `data`, `hazard`.
  - The macro is honoured inside `fwd_mux`.
- The storage array and write logic stay in `regfile`.

## Test plan
- Reset, then read all 32 addresses with no forwarding → every value 0 and `stall_req_o` = 0.
- WB writes `0xDEADBEEF` to r5, then r5 is read the next cycle → `0xDEADBEEF`. A WB write of `0x1234` to r0 → r0 reads 0.
- r7 = `0x11` in the array, MEM writes r7 = `0x22` and EX writes r7 = `0x33` in the same cycle → port reads `0x33`. With EX deasserted → `0x22`.
- EX load to r9 (`ex_is_load_i` = 1) with `rd2_addr_i` = 9 → `rd2_data_o` = 0 and `stall_req_o` = 1. The same case with `rd2_en_i` = 0, or with address 0 → `stall_req_o` = 0.
- WB writes r3 = `0xCAFE` and r3 is read in the same cycle:
  - With `REGFILE_WB_BYPASS_EN` → `0xCAFE`.
  - Without it → the previous value. The next cycle returns `0xCAFE` in both builds.
- WB writes r4 = `0x55` with `rst` high in the same cycle → r4 reads 0 after reset deasserts.

Source files
------------

// File: rtl/regfile_pkg.sv
// ============================================================================
//  Package : project_types
//  Shared register-file types: write-register bundle, data/address types and
//  the $zero constants.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package project_types;

   localparam int REG_AW = 5;

   typedef logic [REG_AW-1:0] reg_addr_t;
   typedef logic [31:0]       reg_data_t;

   typedef struct packed {
      logic      en;
      reg_addr_t addr;
      reg_data_t data;
   } reg_t;

   localparam reg_data_t ZERO_WORD = 32'h0000_0000;
   localparam reg_addr_t REG_ZERO  = 5'd0;

   function automatic logic addr_hit(input reg_t w, input reg_addr_t a);
      return w.en && (w.addr == a);
   endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_fwd_mux.sv
// ============================================================================
//  Module  : fwd_mux
//  One read port's operand resolution: EX > MEM > (WB) > array, $zero forced,
//  load-use hazard flagged on an EX load match. Macro: REGFILE_WB_BYPASS_EN.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module fwd_mux
   import project_types::*;
(
   input  logic      en,
   input  reg_addr_t addr,
   input  reg_t      ex,
   input  logic      ex_is_load,
   input  reg_t      mem,
   input  reg_t      wb,
   input  reg_data_t array_data,
   output reg_data_t data,
   output logic      hazard
);

`ifndef REGFILE_WB_BYPASS_EN
   logic unused_wb;
   assign unused_wb = ^wb;
`endif

   always_comb begin
      data   = ZERO_WORD;
      hazard = 1'b0;
      if (en && (addr != REG_ZERO)) begin
         if (addr_hit(ex, addr)) begin
            // EX load result does not exist yet: return 0 and request a stall
            if (ex_is_load) begin
               hazard = 1'b1;
            end else begin
               data = ex.data;
            end
         end else if (addr_hit(mem, addr)) begin
            data = mem.data;
`ifdef REGFILE_WB_BYPASS_EN
         end else if (addr_hit(wb, addr)) begin
            data = wb.data;
`endif
         end else begin
            data = array_data;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/regfile.sv
// ============================================================================
//  Module  : regfile
//  32x32 MIPS register file with two forwarding read ports and load-use
//  stall request. Macro: REGFILE_WB_BYPASS_EN (same-cycle WB write-through).
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module regfile
   import project_types::*;
#(
   parameter int NREGS = 32,
   parameter int DW    = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  reg_t          wb_wreg_i,
   input  reg_t          ex_wreg_i,
   input  logic          ex_is_load_i,
   input  reg_t          mem_wreg_i,
   input  logic          rd1_en_i,
   input  reg_addr_t     rd1_addr_i,
   output logic [DW-1:0] rd1_data_o,
   input  logic          rd2_en_i,
   input  reg_addr_t     rd2_addr_i,
   output logic [DW-1:0] rd2_data_o,
   output logic          stall_req_o
);

   reg_data_t regs_q [NREGS];
   reg_data_t regs_d [NREGS];

   always_comb begin
      regs_d = regs_q;
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = ZERO_WORD;
         end
      end else if (wb_wreg_i.en && (wb_wreg_i.addr != REG_ZERO)) begin
         regs_d[wb_wreg_i.addr] = wb_wreg_i.data;
      end
   end

   always_ff @(posedge clk) begin
      regs_q <= regs_d;
   end

   // Reset is folded into the port enable so both data and hazard read 0
   logic      rd1_en_w;
   logic      rd2_en_w;
   reg_data_t rd1_data_w;
   reg_data_t rd2_data_w;
   logic      rd1_haz_w;
   logic      rd2_haz_w;

   assign rd1_en_w = rd1_en_i && !rst;
   assign rd2_en_w = rd2_en_i && !rst;

   fwd_mux u_fwd1 (
      .en         (rd1_en_w),
      .addr       (rd1_addr_i),
      .ex         (ex_wreg_i),
      .ex_is_load (ex_is_load_i),
      .mem        (mem_wreg_i),
      .wb         (wb_wreg_i),
      .array_data (regs_q[rd1_addr_i]),
      .data       (rd1_data_w),
      .hazard     (rd1_haz_w)
   );

   fwd_mux u_fwd2 (
      .en         (rd2_en_w),
      .addr       (rd2_addr_i),
      .ex         (ex_wreg_i),
      .ex_is_load (ex_is_load_i),
      .mem        (mem_wreg_i),
      .wb         (wb_wreg_i),
      .array_data (regs_q[rd2_addr_i]),
      .data       (rd2_data_w),
      .hazard     (rd2_haz_w)
   );

   assign rd1_data_o  = rd1_data_w;
   assign rd2_data_o  = rd2_data_w;
   assign stall_req_o = rd1_haz_w | rd2_haz_w;

endmodule

`default_nettype wire

// File: tb/tb_regfile.sv
// ============================================================================
//  Module  : tb_regfile
//  Scoreboard bench for regfile: stimulus queues expected port values, a
//  mid-cycle monitor pops and compares. Macro: REGFILE_WB_BYPASS_EN.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_regfile;
   import project_types::*;

   typedef struct {
      string     tag;
      reg_data_t r1;
      reg_data_t r2;
      logic      st;
   } exp_t;

   logic      clk = 1'b0;
   logic      rst = 1'b1;
   reg_t      wb_wreg_i  = '0;
   reg_t      ex_wreg_i  = '0;
   logic      ex_is_load_i = 1'b0;
   reg_t      mem_wreg_i = '0;
   logic      rd1_en_i = 1'b0;
   reg_addr_t rd1_addr_i = '0;
   logic      rd2_en_i = 1'b0;
   reg_addr_t rd2_addr_i = '0;
   reg_data_t rd1_data_o;
   reg_data_t rd2_data_o;
   logic      stall_req_o;

   exp_t exp_q[$];
   logic chk_vld = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   regfile #(.NREGS(32), .DW(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .wb_wreg_i    (wb_wreg_i),
      .ex_wreg_i    (ex_wreg_i),
      .ex_is_load_i (ex_is_load_i),
      .mem_wreg_i   (mem_wreg_i),
      .rd1_en_i     (rd1_en_i),
      .rd1_addr_i   (rd1_addr_i),
      .rd1_data_o   (rd1_data_o),
      .rd2_en_i     (rd2_en_i),
      .rd2_addr_i   (rd2_addr_i),
      .rd2_data_o   (rd2_data_o),
      .stall_req_o  (stall_req_o)
   );

   function automatic reg_t mk(input logic en, input int a, input reg_data_t d);
      reg_t w;
      w.en   = en;
      w.addr = a[4:0];
      w.data = d;
      return w;
   endfunction

   // Drive one cycle's inputs just after the rising edge
   task automatic drive(input logic r, input reg_t wb, input reg_t ex, input logic ld,
                        input reg_t mem, input logic e1, input int a1,
                        input logic e2, input int a2);
      @(posedge clk);
      #1;
      rst          = r;
      wb_wreg_i    = wb;
      ex_wreg_i    = ex;
      ex_is_load_i = ld;
      mem_wreg_i   = mem;
      rd1_en_i     = e1;
      rd1_addr_i   = a1[4:0];
      rd2_en_i     = e2;
      rd2_addr_i   = a2[4:0];
      chk_vld      = 1'b0;
   endtask

   task automatic expect_out(input string tag, input reg_data_t r1, input reg_data_t r2,
                             input logic st);
      exp_t e;
      e.tag = tag;
      e.r1  = r1;
      e.r2  = r2;
      e.st  = st;
      exp_q.push_back(e);
      chk_vld = 1'b1;
   endtask

   // Monitor: outputs are combinational, so sample at the falling edge
   always @(negedge clk) begin
      if (chk_vld) begin
         exp_t e;
         checks = checks + 1;
         if (exp_q.size() == 0) begin
            errors = errors + 1;
            $display("FAIL scoreboard_empty: output presented with no expectation queued");
         end else begin
            e = exp_q.pop_front();
            if (rd1_data_o !== e.r1) begin
               errors = errors + 1;
               $display("FAIL %s rd1_data: got %h expected %h", e.tag, rd1_data_o, e.r1);
            end
            checks = checks + 1;
            if (rd2_data_o !== e.r2) begin
               errors = errors + 1;
               $display("FAIL %s rd2_data: got %h expected %h", e.tag, rd2_data_o, e.r2);
            end
            checks = checks + 1;
            if (stall_req_o !== e.st) begin
               errors = errors + 1;
               $display("FAIL %s stall: got %b expected %b", e.tag, stall_req_o, e.st);
            end
         end
         chk_vld = 1'b0;
      end
   end

   localparam reg_t NONE = '0;

   initial begin
      // Reset with pending WB write to r4 and an EX load hit; all masked
      drive(1, mk(1, 4, 32'h55), NONE, 0, NONE, 1, 5, 1, 7);
      drive(1, mk(1, 4, 32'h55), mk(1, 5, 32'h99), 1, NONE, 1, 5, 1, 7);
      expect_out("reset", 32'h0, 32'h0, 1'b0);

      for (int i = 0; i < 32; i++) begin
         drive(0, NONE, NONE, 0, NONE, 1, i, 1, 31 - i);
         expect_out($sformatf("post_reset_r%0d", i), 32'h0, 32'h0, 1'b0);
      end

      drive(0, mk(1, 5, 32'hDEADBEEF), NONE, 0, NONE, 1, 6, 0, 5);
      expect_out("wb_r5_issue", 32'h0, 32'h0, 1'b0);
      drive(0, mk(1, 0, 32'h1234), NONE, 0, NONE, 1, 5, 1, 0);
      expect_out("r5_readback", 32'hDEADBEEF, 32'h0, 1'b0);
      drive(0, NONE, NONE, 0, NONE, 1, 0, 1, 5);
      expect_out("r0_discard", 32'h0, 32'hDEADBEEF, 1'b0);

      drive(0, mk(1, 7, 32'h11), NONE, 0, NONE, 0, 7, 0, 7);
      expect_out("wb_r7_issue", 32'h0, 32'h0, 1'b0);
      drive(0, NONE, mk(1, 7, 32'h33), 0, mk(1, 7, 32'h22), 1, 7, 1, 7);
      expect_out("ex_over_mem", 32'h33, 32'h33, 1'b0);
      drive(0, NONE, NONE, 0, mk(1, 7, 32'h22), 1, 7, 1, 7);
      expect_out("mem_over_array", 32'h22, 32'h22, 1'b0);
      drive(0, NONE, NONE, 0, NONE, 1, 7, 1, 7);
      expect_out("array_r7", 32'h11, 32'h11, 1'b0);

      drive(0, NONE, mk(1, 9, 32'hAAAA), 1, NONE, 1, 7, 1, 9);
      expect_out("load_use", 32'h11, 32'h0, 1'b1);
      drive(0, NONE, mk(1, 9, 32'hAAAA), 1, mk(1, 9, 32'h77), 1, 9, 1, 9);
      expect_out("load_use_both", 32'h0, 32'h0, 1'b1);
      drive(0, NONE, mk(1, 9, 32'hAAAA), 1, NONE, 1, 7, 0, 9);
      expect_out("load_use_rd_dis", 32'h11, 32'h0, 1'b0);
      drive(0, NONE, mk(1, 0, 32'hAAAA), 1, NONE, 1, 0, 1, 0);
      expect_out("load_use_addr0", 32'h0, 32'h0, 1'b0);
      drive(0, NONE, NONE, 0, mk(1, 9, 32'h77), 1, 7, 1, 9);
      expect_out("mem_load_fwd", 32'h11, 32'h77, 1'b0);
      drive(0, NONE, mk(1, 9, 32'h99), 0, NONE, 1, 9, 1, 5);
      expect_out("ex_alu_fwd", 32'h99, 32'hDEADBEEF, 1'b0);
      drive(0, NONE, mk(1, 0, 32'hFFFF), 0, mk(1, 0, 32'hEEEE), 1, 0, 1, 0);
      expect_out("zero_no_fwd", 32'h0, 32'h0, 1'b0);

      drive(0, mk(1, 3, 32'hCAFE), NONE, 0, NONE, 1, 3, 1, 7);
`ifdef REGFILE_WB_BYPASS_EN
      expect_out("wb_same_cycle", 32'hCAFE, 32'h11, 1'b0);
`else
      expect_out("wb_same_cycle", 32'h0, 32'h11, 1'b0);
`endif
      drive(0, mk(1, 3, 32'hBEEF), NONE, 0, mk(1, 3, 32'h44), 1, 3, 0, 3);
      expect_out("mem_over_wb", 32'h44, 32'h0, 1'b0);
      drive(0, NONE, NONE, 0, NONE, 1, 3, 1, 7);
      expect_out("r3_readback", 32'hBEEF, 32'h11, 1'b0);

      drive(1, mk(1, 3, 32'h55), mk(1, 3, 32'h1), 1, NONE, 1, 3, 1, 5);
      expect_out("mid_reset", 32'h0, 32'h0, 1'b0);
      drive(0, NONE, NONE, 0, NONE, 1, 3, 1, 5);
      expect_out("after_mid_reset", 32'h0, 32'h0, 1'b0);

      drive(0, NONE, NONE, 0, NONE, 0, 0, 0, 0);
      @(posedge clk);
      @(posedge clk);
      checks = checks + 1;
      if (exp_q.size() != 0) begin
         errors = errors + 1;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
